// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and entry type for the instruction-fetch front end
package fetch_pkg;

  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h00000013;

  typedef struct packed {
    logic [63:0]       pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular decoupling queue between fetch and decode
module fetch_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           entry,
  input  logic                       pop,
  input  logic                       clear,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Head is read from registered storage only, so a write is visible one cycle later.
  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop) occupancy <= occupancy + OCC_W'(1);
      else if (pop && !push) occupancy <= occupancy - OCC_W'(1);
    end
  end

  full_push_pop: assert property (@(posedge clk) disable iff (reset || clear)
    !(push && pop && occupancy == OCC_W'(DEPTH)));

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - PC generator, credit-limited imem request port and decode queue
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              DEPTH    = 4,
  parameter int              IMEM_AW  = 14,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req,
  output logic [IMEM_AW-1:0]         imem_addr,
  input  logic [INST_W-1:0]          imem_rdata,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  input  logic                       deq_ready,
  output logic                       deq_valid,
  output logic [INST_W-1:0]          deq_inst,
  output logic [XLEN-1:0]            deq_pc,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [XLEN-1:0]            fetch_pc
);

  localparam int OCC_W   = $clog2(DEPTH+1);
  localparam int ENTRY_W = XLEN + INST_W;
  localparam logic [OCC_W:0] CREDITS = (OCC_W+1)'(DEPTH);

  logic               inflight;
  logic               deq_fire;
  logic               issue;
  logic               push;
  logic [XLEN-1:0]    pc_q;
  logic [XLEN-1:0]    redirect_aligned;
  logic [OCC_W:0]     committed;
  logic [ENTRY_W-1:0] head;

  assign deq_valid        = (occupancy != '0);
  assign deq_fire         = deq_valid & deq_ready & ~redirect_valid;
  assign redirect_aligned = redirect_pc & ~XLEN'(3);

  // Count held plus outstanding entries, less the one leaving, so the queue can never overflow.
  assign committed = {1'b0, occupancy} + (OCC_W+1)'(inflight) - (OCC_W+1)'(deq_fire);
  assign issue     = ~reset & ~redirect_valid & (committed < CREDITS);
  assign imem_req  = issue;
  assign imem_addr = fetch_pc[IMEM_AW+1:2];
  assign push      = inflight & ~redirect_valid;

  assign {deq_pc, deq_inst} = head;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      pc_q     <= '0;
      inflight <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_aligned;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc_q     <= fetch_pc;
        fetch_pc <= fetch_pc + XLEN'(4);
      end
    end
  end

  fetch_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .entry     ({pc_q, imem_rdata}),
    .pop       (deq_fire),
    .clear     (redirect_valid),
    .head      (head),
    .occupancy (occupancy)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed checks of fetch_queue at DEPTH 4 and a DEPTH 2 random-stall stream
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [13:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        deq_ready = 1'b0;
  logic        deq_valid;
  logic [31:0] deq_inst;
  logic [63:0] deq_pc;
  logic [2:0]  occupancy;
  logic [63:0] fetch_pc;

  logic        reset2 = 1'b1;
  logic        imem_req2;
  logic [13:0] imem_addr2;
  logic [31:0] imem_rdata2;
  logic        redirect_valid2 = 1'b0;
  logic [63:0] redirect_pc2 = '0;
  logic        deq_ready2 = 1'b0;
  logic        deq_valid2;
  logic [31:0] deq_inst2;
  logic [63:0] deq_pc2;
  logic [1:0]  occupancy2;
  logic [63:0] fetch_pc2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_queue #(.XLEN(64), .DEPTH(4), .IMEM_AW(14), .RESET_PC(64'h0)) u_dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .deq_ready(deq_ready), .deq_valid(deq_valid), .deq_inst(deq_inst), .deq_pc(deq_pc),
    .occupancy(occupancy), .fetch_pc(fetch_pc)
  );

  fetch_queue #(.XLEN(64), .DEPTH(2), .IMEM_AW(14), .RESET_PC(64'h0)) u_dut2 (
    .clk(clk), .reset(reset2), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_rdata(imem_rdata2), .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
    .deq_ready(deq_ready2), .deq_valid(deq_valid2), .deq_inst(deq_inst2), .deq_pc(deq_pc2),
    .occupancy(occupancy2), .fetch_pc(fetch_pc2)
  );

  function automatic logic [31:0] inst_of(input logic [13:0] a);
    return 32'hC0DE_0000 ^ {18'd0, a};
  endfunction

  // Synchronous instruction memory: data one cycle after the address.
  always @(posedge clk) begin
    imem_rdata  <= inst_of(imem_addr);
    imem_rdata2 <= inst_of(imem_addr2);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic begin_cycle(input logic r, input logic rdy, input logic rv, input logic [63:0] rpc);
    @(negedge clk);
    reset          = r;
    deq_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    begin_cycle(1'b1, rdy, 1'b0, 64'h0);
    begin_cycle(1'b1, rdy, 1'b0, 64'h0);
    check("rst_occ", 64'(occupancy), 64'd0);
    check("rst_valid", 64'(deq_valid), 64'd0);
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_fetch_pc", fetch_pc, 64'h0);
  endtask

  task automatic expect_head(input string tag, input logic [63:0] pc);
    check({tag, "_valid"}, 64'(deq_valid), 64'd1);
    check({tag, "_pc"}, deq_pc, pc);
    check({tag, "_inst"}, 64'(deq_inst), 64'(inst_of(pc[15:2])));
  endtask

  initial begin
    logic [63:0] exp_pc;
    logic [15:0] lfsr;
    int          n_deq;

    // Steady state: one instruction per cycle from R+2.
    do_reset(1'b1);
    check("rst_deq_pc", deq_pc, 64'h0);
    check("rst_deq_inst", 64'(deq_inst), 64'h0);
    begin_cycle(1'b0, 1'b1, 1'b0, 64'h0);
    check("r_req", 64'(imem_req), 64'd1);
    check("r_addr", 64'(imem_addr), 64'h0);
    begin_cycle(1'b0, 1'b1, 1'b0, 64'h0);
    check("r1_valid", 64'(deq_valid), 64'd0);
    exp_pc = 64'h0;
    for (int k = 0; k < 10; k++) begin
      begin_cycle(1'b0, 1'b1, 1'b0, 64'h0);
      expect_head("stream", exp_pc);
      exp_pc += 64'd4;
    end

    // Stall for 10 cycles, then drain in order.
    do_reset(1'b0);
    for (int c = 0; c < 10; c++) begin
      begin_cycle(1'b0, 1'b0, 1'b0, 64'h0);
      if (c == 3) check("stall_req_r3", 64'(imem_req), 64'd1);
      if (c >= 4) check("stall_req_low", 64'(imem_req), 64'd0);
      if (c >= 5) check("stall_occ", 64'(occupancy), 64'd4);
    end
    for (int k = 0; k < 6; k++) begin
      begin_cycle(1'b0, 1'b1, 1'b0, 64'h0);
      expect_head("drain", 64'(k * 4));
    end

    // Redirect with three held entries and a fetch in flight.
    do_reset(1'b0);
    for (int c = 0; c < 4; c++) begin_cycle(1'b0, 1'b0, 1'b0, 64'h0);
    check("pre_redir_occ2", 64'(occupancy), 64'd2);
    begin_cycle(1'b0, 1'b1, 1'b1, 64'h1002);
    check("redir_t_occ", 64'(occupancy), 64'd3);
    check("redir_t_req", 64'(imem_req), 64'd0);
    begin_cycle(1'b0, 1'b1, 1'b0, 64'h0);
    check("redir_t1_occ", 64'(occupancy), 64'd0);
    check("redir_t1_valid", 64'(deq_valid), 64'd0);
    check("redir_t1_req", 64'(imem_req), 64'd1);
    check("redir_t1_fetch_pc", fetch_pc, 64'h1000);
    check("redir_t1_addr", 64'(imem_addr), 64'h400);
    begin_cycle(1'b0, 1'b1, 1'b0, 64'h0);
    check("redir_t2_valid", 64'(deq_valid), 64'd0);
    begin_cycle(1'b0, 1'b1, 1'b0, 64'h0);
    expect_head("redir_t3", 64'h1000);
    begin_cycle(1'b0, 1'b1, 1'b0, 64'h0);
    expect_head("redir_t4", 64'h1004);

    // Redirect to the top of the address space; PC and imem_addr wrap.
    begin_cycle(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    begin_cycle(1'b0, 1'b1, 1'b0, 64'h0);
    check("wrap_t1_fetch_pc", fetch_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_t1_addr", 64'(imem_addr), 64'h3FFF);
    begin_cycle(1'b0, 1'b1, 1'b0, 64'h0);
    check("wrap_t2_fetch_pc", fetch_pc, 64'h0);
    check("wrap_t2_addr", 64'(imem_addr), 64'h0);
    begin_cycle(1'b0, 1'b1, 1'b0, 64'h0);
    expect_head("wrap_t3", 64'hFFFF_FFFF_FFFF_FFFC);
    begin_cycle(1'b0, 1'b1, 1'b0, 64'h0);
    expect_head("wrap_t4", 64'h0);

    // Back-to-back redirects: the second one wins.
    begin_cycle(1'b0, 1'b1, 1'b1, 64'h2000);
    begin_cycle(1'b0, 1'b1, 1'b1, 64'h3000);
    check("b2b_req", 64'(imem_req), 64'd0);
    begin_cycle(1'b0, 1'b1, 1'b0, 64'h0);
    check("b2b_fetch_pc", fetch_pc, 64'h3000);
    begin_cycle(1'b0, 1'b1, 1'b0, 64'h0);
    check("b2b_valid_early", 64'(deq_valid), 64'd0);
    begin_cycle(1'b0, 1'b1, 1'b0, 64'h0);
    expect_head("b2b", 64'h3000);

    // One-cycle reset with two entries held and one in flight.
    do_reset(1'b0);
    for (int c = 0; c < 3; c++) begin_cycle(1'b0, 1'b0, 1'b0, 64'h0);
    begin_cycle(1'b1, 1'b0, 1'b0, 64'h0);
    check("mid_rst_occ_before", 64'(occupancy), 64'd2);
    check("mid_rst_req", 64'(imem_req), 64'd0);
    begin_cycle(1'b0, 1'b1, 1'b0, 64'h0);
    check("mid_rst_occ", 64'(occupancy), 64'd0);
    check("mid_rst_valid", 64'(deq_valid), 64'd0);
    check("mid_rst_fetch_pc", fetch_pc, 64'h0);
    check("mid_rst_req_r", 64'(imem_req), 64'd1);
    begin_cycle(1'b0, 1'b1, 1'b0, 64'h0);
    check("mid_rst_r1_valid", 64'(deq_valid), 64'd0);
    begin_cycle(1'b0, 1'b1, 1'b0, 64'h0);
    expect_head("mid_rst_r2", 64'h0);
    begin_cycle(1'b0, 1'b1, 1'b0, 64'h0);
    expect_head("mid_rst_r3", 64'h4);

    // DEPTH 2 with pseudo-random deq_ready from a fixed-seed LFSR.
    @(negedge clk);
    reset2 = 1'b1;
    @(negedge clk);
    lfsr   = 16'hACE1;
    exp_pc = 64'h0;
    n_deq  = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      reset2     = 1'b0;
      deq_ready2 = lfsr[0];
      lfsr       = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      #1;
      check("d2_occ_le2", 64'(occupancy2 <= 2'd2), 64'd1);
      if (deq_valid2 && deq_ready2) begin
        check("d2_pc", deq_pc2, exp_pc);
        check("d2_inst", 64'(deq_inst2), 64'(inst_of(exp_pc[15:2])));
        exp_pc += 64'd4;
        n_deq++;
      end
    end
    check("d2_progress", 64'(n_deq >= 60), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end for the pipelined RV64 core. It replaces the bare PC register and single IF/ID latch with three parts: a PC generator, a synchronous instruction-memory request port, and a DEPTH-entry decoupling queue of {pc, instruction} pairs. Decode pulls entries from the queue with a valid/ready handshake. A redirect from decode (taken branch or jump) flushes the queue and any in-flight fetch, then restarts fetch at the new target.

## Interface
- XLEN, 64, PC width.
- DEPTH, 4, queue entries; power of two, ≥ 2.
- IMEM_AW, 14, instruction-memory word-address width.
- RESET_PC, 64'h0, first fetch address after reset; must be 4-byte aligned.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- imem_req  out  1  read request this cycle.
- imem_addr  out  IMEM_AW  word address, equal to fetch_pc[IMEM_AW+1:2].
- imem_rdata  in  32  instruction; valid exactly one cycle after imem_req.
- redirect_valid  in  1  flush the queue and refetch from redirect_pc.
- redirect_pc  in  XLEN  redirect target; bits [1:0] are forced to 0 internally.
- deq_ready  in  1  decode accepts the head entry (this is ~StallD).
- deq_valid  out  1  head entry is present.
- deq_inst  out  32  head instruction.
- deq_pc  out  XLEN  head PC.
- occupancy  out  $clog2(DEPTH+1)  entries currently held.
- fetch_pc  out  XLEN  next address to be requested (debug).

## Operation
- **Dequeue fire:** deq_fire = deq_valid & deq_ready & ~redirect_valid.
- **Request issue:** issue = ~reset & ~redirect_valid & (occupancy + inflight − deq_fire < DEPTH).
  - inflight is a 1-bit register set by issue, so at most one fetch is outstanding.
  - imem_req = issue.
  - On issue, fetch_pc ← fetch_pc + 4; addition is modulo 2^XLEN and wraps silently.
- **Response capture:** the cycle after an issue, {pc_q, imem_rdata} is written at the tail.
  - pc_q is the fetch_pc value registered at issue.
  - The write is suppressed if redirect_valid is high in the response cycle.
- **Queue:** circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
  - Head outputs come from registered storage; there is no combinational path from imem_rdata to deq_*.
  - deq_valid = (occupancy ≠ 0).
- **Simultaneous write and deq_fire** when occupancy = DEPTH is impossible by the credit rule.
  - If it does occur, the simulation-only assertion fires.
  - Write and read at occupancy 0 is not a bypass; the entry becomes visible next cycle.
- **Redirect** takes priority over every other event in its cycle:
  - occupancy ← 0, pointers ← 0, inflight ← 0;
  - the response arriving this cycle is dropped;
  - no request is issued;
  - no dequeue is performed, even if deq_ready is high;
  - fetch_pc ← {redirect_pc[XLEN-1:2], 2'b00}.
- **Redirect while empty or idle** is legal and restarts fetch the same way.
- **Back-to-back redirects:** the last one wins; each one restarts the sequence.

## Timing
- **Reset values:** fetch_pc = RESET_PC, occupancy = 0, deq_valid = 0, imem_req = 0, inflight = 0.
  - deq_inst and deq_pc are don't-care while deq_valid = 0; they are driven to 0 at reset.
- **Reset asserted mid-operation:** all state returns to reset values on the next edge. Any in-flight response is discarded.
- **First fetch:** imem_req is high in the first cycle after reset deasserts (cycle R).
  - Data arrives at R+1.
  - deq_valid rises at R+2 with deq_pc = RESET_PC.
- **Redirect latency:** redirect in cycle T, request for the target at T+1, deq_valid for the target at T+3.
- **Steady state:** with deq_ready held high, one instruction per cycle.
- **Stall:** with deq_ready held low, occupancy saturates at DEPTH and imem_req goes low once occupancy + inflight = DEPTH.

## Structure
- Shared package `fetch_pkg`: INST_W = 32, NOP_INST = 32'h00000013, and the entry struct {pc, inst}.
- One sub-module, `fetch_fifo`, parametrised on entry width and DEPTH. Its ports: push, pop, clear, head, occupancy.
- PC generator, credit logic and inflight tracking live in the top module.

## Test plan
- **Reset, deq_ready = 1:** deq_pc sequence 0x0, 0x4, 0x8, … starting at R+2, with deq_valid continuous and no gaps.
- **deq_ready = 0 for 10 cycles from R, DEPTH = 4:** occupancy reaches exactly 4, and imem_req is low from R+4 while the stall persists.
  - On release, the four held entries dequeue in order with PCs 0x0 to 0xC, and no duplicates or drops.
- **Redirect to 0x1002 while occupancy = 3 and a fetch is in flight:** the next deq_pc is 0x1000, at T+3.
  - No stale entry, and no dequeue in cycle T despite deq_ready = 1.
- **Redirect to 0xFFFF_FFFF_FFFF_FFFC:** the following deq_pc is 0x0 (wrap), with imem_addr wrapping modulo 2^IMEM_AW.
- **Reset asserted for one cycle while occupancy = 2 and inflight = 1:** next cycle occupancy = 0, deq_valid = 0, fetch_pc = RESET_PC, then normal restart.
- **DEPTH = 2 with random deq_ready (seed fixed):** the scoreboard sees an in-order, gap-free PC stream and occupancy never exceeds 2.
